// File: rtl/rp2a03_dma_pkg.sv
// rp2a03_dma_pkg: shared states, default OAM data port address and count-width helper for the DMA engine
package rp2a03_dma_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_SPR_READ,
        S_SPR_WRITE,
        S_DMC_READ,
        S_DONE
    } dma_state_t;

    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction
endpackage

// File: rtl/rp2a03_dma_gen.sv
// rp2a03_dma_gen: sprite/DMC DMA engine that halts the CPU, aligns to get/put parity and owns the bus
module rp2a03_dma_gen
    import rp2a03_dma_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 8,
    parameter int                SPR_LEN  = 256,
    parameter logic [ADDR_W-1:0] SPR_DEST = ADDR_W'(OAM_DATA_ADDR),
    parameter int                ALIGN_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cpu_clk,
    input  logic              i_spr_trig,
    input  logic              i_dmc_trig,
    input  logic              i_cpu_r_nw,
    input  logic [DATA_W-1:0] i_from_cpu,
    input  logic [DATA_W-1:0] i_from_ram,
    input  logic [ADDR_W-1:0] i_dmc_dma_addr,
    output logic [ADDR_W-1:0] o_a_out,
    output logic              o_dma_active,
    output logic              o_dma_r_nw,
    output logic [DATA_W-1:0] o_to_ram,
    output logic [DATA_W-1:0] o_dmc_data,
    output logic              o_dmc_ack,
    output logic              o_spr_busy
);
    localparam int CW = cnt_w(SPR_LEN);

    dma_state_t        r_state, w_state_nx, w_disp;
    logic              r_get_cyc, r_spr_pend, w_pend_nx, w_pend_eff;
    logic              w_next_get, w_dmc_req;
    logic [CW-1:0]     r_count, w_count_nx, w_count_inc;
    logic [DATA_W-1:0] r_page, w_page_nx;
    logic [ADDR_W-1:0] w_addr;

    // dispatch looks at the parity of the cycle being entered, not the one ending
    assign w_next_get  = (ALIGN_EN == 0) || !r_get_cyc;
    assign w_count_inc = r_count + 1'b1;
    assign w_pend_eff  = r_spr_pend && !(r_state == S_SPR_WRITE && w_count_inc == CW'(SPR_LEN));
    assign w_dmc_req   = i_dmc_trig && r_state != S_DMC_READ;
    assign w_disp      = (w_dmc_req && w_next_get)  ? S_DMC_READ :
                         (w_pend_eff && w_next_get) ? S_SPR_READ :
                         (w_pend_eff || w_dmc_req)  ? S_ALIGN    : S_DONE;
    assign w_addr      = (r_state == S_SPR_READ)  ? ADDR_W'({r_page, 8'(r_count)}) :
                         (r_state == S_SPR_WRITE) ? SPR_DEST :
                         (r_state == S_DMC_READ)  ? i_dmc_dma_addr : o_a_out;

    always_comb begin
        w_state_nx = r_state;
        w_pend_nx  = r_spr_pend;
        w_count_nx = r_count;
        w_page_nx  = r_page;
        case (r_state)
            S_IDLE: begin
                if (i_spr_trig) begin
                    w_pend_nx  = 1'b1;
                    w_count_nx = '0;
                    w_page_nx  = i_from_cpu;
                end
                if (i_spr_trig || i_dmc_trig) w_state_nx = S_HALT;
            end
            S_HALT:               if (i_cpu_r_nw) w_state_nx = w_disp;
            S_SPR_READ:           w_state_nx = S_SPR_WRITE;
            S_SPR_WRITE: begin
                w_count_nx = w_count_inc;
                w_pend_nx  = w_pend_eff;
                w_state_nx = w_disp;
            end
            S_ALIGN, S_DMC_READ:  w_state_nx = w_disp;
            S_DONE:               if (i_cpu_r_nw) w_state_nx = S_IDLE;
            default:              w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_get_cyc  <= 1'b1;
            r_spr_pend <= 1'b0;
            r_count    <= '0;
            r_page     <= '0;
        end else if (i_cpu_clk) begin
            r_state    <= w_state_nx;
            r_get_cyc  <= !r_get_cyc;
            r_spr_pend <= w_pend_nx;
            r_count    <= w_count_nx;
            r_page     <= w_page_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_a_out      <= '0;
            o_dma_active <= 1'b0;
            o_dma_r_nw   <= 1'b1;
            o_to_ram     <= '0;
            o_dmc_data   <= '0;
            o_dmc_ack    <= 1'b0;
            o_spr_busy   <= 1'b0;
        end else begin
            o_a_out      <= w_addr;
            o_dma_active <= r_state != S_IDLE && r_state != S_DONE;
            o_dma_r_nw   <= r_state != S_SPR_WRITE;
            o_dmc_ack    <= r_state == S_DMC_READ;
            o_spr_busy   <= r_spr_pend;
            if (i_cpu_clk && r_state == S_SPR_READ) o_to_ram <= i_from_ram;
            if (i_cpu_clk && r_state == S_DMC_READ) o_dmc_data <= i_from_ram;
        end
    end
endmodule

// File: tb/tb_rp2a03_dma_gen.sv
// tb_rp2a03_dma_gen: table-driven sprite/DMC scenarios plus reset and short-length sequences
module tb_rp2a03_dma_gen;
    logic        clk = 0, rst = 1, cpu_clk = 0, cpu_r_nw = 1;
    logic        spr_trig = 0, dmc_trig = 0, spr_trig4 = 0, dmc_trig4 = 0;
    logic [7:0]  from_cpu = 8'h02;
    logic [15:0] dmc_addr = 16'hC123;
    logic [7:0]  from_ram, to_ram, dmc_data, from_ram4, to4, dmcd4;
    logic [15:0] a_out, a4;
    logic        dma_active, dma_r_nw, dmc_ack, spr_busy;
    logic        act4, rnw4, ack4, busy4;
    logic        m_get = 1, busy_seen = 0;
    int          total = 0, bad = 0, act4n = 0, w4 = 0, bad4 = 0, ph = 0;

    typedef struct packed {
        logic        ack;
        logic        r_nw;
        logic [15:0] addr;
        logic [7:0]  d;
    } ent_t;
    ent_t trace[$];

    typedef struct {
        bit          dmc_only;
        bit          trig_get;
        int          halt_wait;
        int          dmc_at;
        logic [15:0] dmc_addr;
        logic [7:0]  dmc_val;
        int          exp_active;
        int          exp_lead;
        int          exp_writes;
        int          exp_acks;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [7:0] ram(input logic [15:0] a);
        return (a == 16'hC123) ? 8'h5A : a[7:0];
    endfunction
    assign from_ram  = ram(a_out);
    assign from_ram4 = ram(a4);

    rp2a03_dma_gen dut (
        .clk(clk), .rst(rst), .i_cpu_clk(cpu_clk), .i_spr_trig(spr_trig), .i_dmc_trig(dmc_trig),
        .i_cpu_r_nw(cpu_r_nw), .i_from_cpu(from_cpu), .i_from_ram(from_ram), .i_dmc_dma_addr(dmc_addr),
        .o_a_out(a_out), .o_dma_active(dma_active), .o_dma_r_nw(dma_r_nw), .o_to_ram(to_ram),
        .o_dmc_data(dmc_data), .o_dmc_ack(dmc_ack), .o_spr_busy(spr_busy)
    );

    rp2a03_dma_gen #(.SPR_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .i_cpu_clk(cpu_clk), .i_spr_trig(spr_trig4), .i_dmc_trig(dmc_trig4),
        .i_cpu_r_nw(cpu_r_nw), .i_from_cpu(from_cpu), .i_from_ram(from_ram4), .i_dmc_dma_addr(dmc_addr),
        .o_a_out(a4), .o_dma_active(act4), .o_dma_r_nw(rnw4), .o_to_ram(to4),
        .o_dmc_data(dmcd4), .o_dmc_ack(ack4), .o_spr_busy(busy4)
    );

    initial forever #5 clk = ~clk;

    // one cpu tick every third clk, changed just after the edge
    initial forever begin
        @(posedge clk);
        #1;
        cpu_clk = (ph == 2);
        ph = (ph == 2) ? 0 : ph + 1;
    end

    // parity of the current cpu cycle: set by reset, flipped on every tick
    initial forever begin
        @(posedge clk);
        if (rst) m_get = 1;
        else if (cpu_clk) m_get = ~m_get;
    end

    // record one bus entry per cpu cycle on its last clk
    initial forever begin
        @(negedge clk);
        if (!rst && cpu_clk) begin
            if (dma_active) begin
                trace.push_back({dmc_ack, dma_r_nw, a_out, to_ram});
                if (spr_busy) busy_seen = 1;
            end
            if (act4) begin
                act4n++;
                if (!rnw4) begin
                    if (a4 != 16'h2004 || to4 != 8'(w4)) bad4++;
                    w4++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic next_tick();
        do @(negedge clk); while (!cpu_clk);
        #2;
    endtask

    task automatic wait_parity(input bit g);
        int guard = 0;
        do begin next_tick(); guard++; end while (m_get != g && guard < 8);
    endtask

    task automatic run(input vec_t v, input int r);
        int   n, lead, nw, errs, acks, didx, guard;
        bit   fired;
        ent_t e;
        dmc_addr = v.dmc_addr;
        trace.delete();
        busy_seen = 0;
        fired = 0;
        wait_parity(v.trig_get);
        if (v.dmc_only) dmc_trig = 1; else spr_trig = 1;
        next_tick();
        spr_trig = 0;
        if (v.halt_wait > 0) begin
            cpu_r_nw = 0;
            repeat (v.halt_wait) next_tick();
            cpu_r_nw = 1;
        end
        guard = 0;
        while (!(trace.size() > 0 && !dma_active) && guard < 1500) begin
            if (trace.size() > 0) begin
                e = trace[trace.size()-1];
                if (v.dmc_at >= 0 && !fired && !e.r_nw && e.d == 8'(v.dmc_at)) begin
                    dmc_trig = 1;
                    fired = 1;
                end
                if (e.ack) dmc_trig = 0;
            end
            next_tick();
            guard++;
        end
        chk($sformatf("row%0d finished", r), dma_active, 0);
        repeat (3) next_tick();
        n = trace.size(); lead = -1; nw = 0; errs = 0; acks = 0; didx = -1;
        for (int i = 0; i < n; i++) begin
            e = trace[i];
            if (lead < 0 && e.r_nw && !e.ack && e.addr == 16'h0200) lead = i;
            if (!e.r_nw) begin
                if (e.addr != 16'h2004 || e.d != 8'(nw)) errs++;
                nw++;
            end
            if (e.ack) begin
                acks++;
                didx = i;
                if (e.addr != v.dmc_addr || !e.r_nw) errs++;
            end
        end
        chk($sformatf("row%0d active ticks", r), n, v.exp_active);
        chk($sformatf("row%0d first read index", r), lead, v.exp_lead);
        chk($sformatf("row%0d writes", r), nw, v.exp_writes);
        chk($sformatf("row%0d bad bus entries", r), errs, 0);
        chk($sformatf("row%0d dmc acks", r), acks, v.exp_acks);
        chk($sformatf("row%0d busy seen", r), busy_seen, !v.dmc_only);
        chk($sformatf("row%0d busy at end", r), spr_busy, 0);
        if (v.exp_acks > 0) chk($sformatf("row%0d dmc data", r), dmc_data, v.dmc_val);
        if (v.exp_acks > 0 && !v.dmc_only)
            chk($sformatf("row%0d resume addr", r),
                (didx >= 0 && didx + 2 < n) ? trace[didx+2].addr : 16'h0, 16'h0200 + v.dmc_at + 1);
        if (v.dmc_only) chk($sformatf("row%0d dmc is last", r), didx, n - 1);
    endtask

    initial begin
        int   guard;
        ent_t e;
        vecs[0] = '{1'b0, 1'b1, 0, -1,    16'hC123, 8'h5A, 513, 1,  256, 0};
        vecs[1] = '{1'b0, 1'b0, 0, -1,    16'hC123, 8'h5A, 514, 2,  256, 0};
        vecs[2] = '{1'b0, 1'b1, 3, -1,    16'hC123, 8'h5A, 517, 5,  256, 0};
        vecs[3] = '{1'b0, 1'b1, 0, 'h40,  16'hC123, 8'h5A, 515, 1,  256, 1};
        vecs[4] = '{1'b1, 1'b1, 0, -1,    16'hC0A7, 8'hA7, 2,   -1, 0,   1};
        vecs[5] = '{1'b1, 1'b0, 0, -1,    16'hC0A7, 8'hA7, 3,   -1, 0,   1};
        repeat (4) @(negedge clk);
        #2;
        chk("rst a_out", a_out, 0);
        chk("rst dma_active", dma_active, 0);
        chk("rst dma_r_nw", dma_r_nw, 1);
        chk("rst to_ram", to_ram, 0);
        chk("rst dmc_data", dmc_data, 0);
        chk("rst dmc_ack", dmc_ack, 0);
        chk("rst spr_busy", spr_busy, 0);
        rst = 0;
        for (int r = 0; r < 6; r++) run(vecs[r], r);

        // reset in the middle of a sprite copy, at the read of offset 0x80
        dmc_addr = 16'hC123;
        trace.delete();
        wait_parity(1'b1);
        spr_trig = 1;
        next_tick();
        spr_trig = 0;
        guard = 0;
        while (guard < 600) begin
            if (trace.size() > 0) begin
                e = trace[trace.size()-1];
                if (e.r_nw && e.addr == 16'h0280) break;
            end
            next_tick();
            guard++;
        end
        chk("reached offset 0x80", guard < 600, 1);
        rst = 1;
        @(negedge clk);
        #2;
        chk("mid rst dma_active", dma_active, 0);
        chk("mid rst a_out", a_out, 0);
        chk("mid rst spr_busy", spr_busy, 0);
        chk("mid rst dma_r_nw", dma_r_nw, 1);
        rst = 0;
        trace.delete();
        repeat (10) next_tick();
        chk("no bus after rst", trace.size(), 0);
        run(vecs[0], 6);

        // four-byte instance
        act4n = 0; w4 = 0; bad4 = 0;
        wait_parity(1'b1);
        spr_trig4 = 1;
        next_tick();
        spr_trig4 = 0;
        repeat (14) next_tick();
        chk("len4 active ticks", act4n, 9);
        chk("len4 writes", w4, 4);
        chk("len4 bad writes", bad4, 0);
        chk("len4 idle after", act4, 0);
        chk("len4 busy after", busy4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rp2a03_dma_gen.md
Name: rp2a03_dma_gen

Overview:
- Parametrised successor sprite/DMC DMA engine for the RP2A03 CPU wrapper.
- Halts the CPU on a read cycle and aligns to get/put cycle parity.
- Copies SPR_LEN bytes from page from_cpu to SPR_DEST, and lets DMC fetches steal cycles mid-transfer with correct realignment.
- Sits between the CPU core and the bus mux; the bus mux selects a_out and dma_r_nw while dma_active=1.

Parameters:
- ADDR_W, 16, address bus width
- DATA_W, 8, data bus width
- SPR_LEN, 256, bytes per sprite DMA (1..256; count width is clog2(SPR_LEN+1))
- SPR_DEST, 16'h2004, fixed write address for sprite bytes
- ALIGN_EN, 1, 1 = enforce get/put parity with dummy cycles; 0 = no alignment cycles

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_clk  in  1  one-clk enable pulse per CPU cycle; all state transitions occur only on it
- spr_trig  in  1  sprite DMA request; sampled in S_IDLE on a cpu_clk tick
- dmc_trig  in  1  DMC fetch request (level); held until dmc_ack
- cpu_r_nw  in  1  CPU in a read cycle (halt permitted)
- from_cpu  in  DATA_W  source page, latched with spr_trig
- from_ram  in  DATA_W  bus read data
- dmc_dma_addr  in  ADDR_W  DMC fetch address
- a_out  out  ADDR_W  DMA bus address
- dma_active  out  1  DMA owns the bus / CPU halted
- dma_r_nw  out  1  1 = read, 0 = write
- to_ram  out  DATA_W  sprite byte to write
- dmc_data  out  DATA_W  byte captured on DMC fetch
- dmc_ack  out  1  high while the DMC fetch is on the bus
- spr_busy  out  1  sprite transfer in progress

Behaviour:
- States: S_IDLE, S_HALT, S_ALIGN, S_SPR_READ, S_SPR_WRITE, S_DMC_READ, S_DONE.
- Parity flag get_cyc: resets to 1, toggles every cpu_clk tick. With ALIGN_EN=0 it is treated as always matching.
- Reset: state=S_IDLE, get_cyc=1, spr_pend=0, count=0. Outputs: a_out=0, dma_active=0, dma_r_nw=1, to_ram=0, dmc_data=0, dmc_ack=0, spr_busy=0.
- Reset mid-transfer aborts immediately. No further bus writes occur.
- All transitions below take effect on cpu_clk ticks only.
- S_IDLE:
  - spr_trig: latch page=from_cpu, set spr_pend=1, count=0.
  - spr_trig or dmc_trig: go to S_HALT.
- S_HALT: wait while cpu_r_nw=0. When cpu_r_nw=1, go to the dispatch state. This is one halt cycle minimum.
- Dispatch, evaluated after S_HALT, S_SPR_WRITE, S_DMC_READ and S_ALIGN:
  - dmc_trig and get_cyc → S_DMC_READ.
  - else spr_pend and get_cyc → S_SPR_READ.
  - else any pending work (spr_pend or dmc_trig) → S_ALIGN.
  - else → S_DONE.
  - DMC has priority over sprite on the same get cycle.
- S_SPR_READ: address = {page, count[7:0]}. Capture from_ram into to_ram on the last clk of the state. Next state is S_SPR_WRITE; this lands on a put cycle.
- S_SPR_WRITE: address = SPR_DEST, dma_r_nw=0, count+1.
  - If the new count = SPR_LEN, clear spr_pend. Then dispatch.
  - Byte count wraps at the page boundary; the source never crosses pages.
- S_DMC_READ: address = dmc_dma_addr, dmc_ack=1. Capture from_ram into dmc_data. Then dispatch; if the sprite is pending this gives one S_ALIGN before resuming.
- S_ALIGN: dummy read, dma_active=1, address = last a_out, dma_r_nw=1.
- S_DONE: dma_active=0. Return to S_IDLE only when cpu_r_nw=1 (re-arm guard). A spr_trig in S_DONE is ignored.
- Outputs are registered from the current state every clk: one clk latency after a state change, updated within the same cpu cycle.
  - dma_active=1 in S_HALT..S_DMC_READ.
  - spr_busy = spr_pend.
- Timing (ALIGN_EN=1, no DMC): 1 halt + (0|1) align + 2·SPR_LEN cpu ticks; 513 or 514 for SPR_LEN=256.
- Each DMC steal during a sprite transfer adds 2 ticks: the read plus one realign.
- dmc_trig with no sprite pending: halt → (align) → DMC read → S_DONE. Costs 2–3 ticks plus any write-wait.
- spr_trig and dmc_trig together in S_IDLE: both are accepted, and DMC is served first.

Decomposition:
- Package rp2a03_dma_pkg: state enum dma_state_t, constant OAM_DATA_ADDR=16'h2004 (default for SPR_DEST), and the count-width function.
- Single module; no sub-module is warranted. The parity flag and byte counter are inline registers.

Test Plan:
- from_cpu=8'h02, spr_trig on get_cyc=1, cpu_r_nw=1, RAM[0x0200+i]=i → 256 writes to 0x2004 with data 0..255; dma_active for 513 ticks; then S_IDLE.
- Same trigger on a put cycle → exactly one S_ALIGN dummy before the first read at 0x0200; 514 ticks total.
- cpu_r_nw=0 for 3 ticks after spr_trig → S_HALT holds 3 extra ticks and no bus access until cpu_r_nw=1.
- dmc_trig asserted during byte 0x40's write, dmc_dma_addr=16'hC123, RAM=8'h5A → DMC read at 0xC123, dmc_ack for one tick, dmc_data=8'h5A. Then one align, resume read at 0x0241; 515 ticks total.
- SPR_LEN=4 and dmc_trig alone: sprite copies 4 bytes then S_DONE. Standalone DMC finishes in 2–3 ticks with spr_busy=0 throughout.
- rst asserted at byte 0x80 → next clk: dma_active=0, a_out=0, spr_busy=0, state S_IDLE. A new spr_trig restarts from offset 0.
